m_axi_lite_cmd: RTL and testbench

//  Single-outstanding AXI4-Lite master that turns simple user commands into AXI4-Lite bus transactions.
//  - Accepts one read or write command at a time on a valid/ready command port.
//  - Drives the AW/W/B or AR/R channels.
//  - Returns the response (read data, RESP code) on a valid/ready response port.

---
 rtl/axi_lite_pkg.sv | 27 ++
 rtl/m_axi_lite_cmd.sv | 241 ++++++++++++++++++++++++
 tb/tb_m_axi_lite_cmd.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes, protection default and the command master's FSM encoding.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WR    = 3'd1;
   localparam logic [2:0] S_WRESP = 3'd2;
   localparam logic [2:0] S_RADDR = 3'd3;
   localparam logic [2:0] S_RDATA = 3'd4;
   localparam logic [2:0] S_RESP  = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE  = S_IDLE,
      ST_WR    = S_WR,
      ST_WRESP = S_WRESP,
      ST_RADDR = S_RADDR,
      ST_RDATA = S_RDATA,
      ST_RESP  = S_RESP
   } state_t;

endpackage

// File: rtl/m_axi_lite_cmd.sv
// Single-outstanding AXI4-Lite master: one user command in, one AXI transaction out, one response back.
// All outputs come straight from registers; the comb process computes every register's next value.
module m_axi_lite_cmd #(
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ADDR_WIDTH = 8
) (
   input  logic                            M_AXI_ACLK,
   input  logic                            M_AXI_ARESETn,
   input  logic                            cmd_valid,
   output logic                            cmd_ready,
   input  logic                            cmd_write,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                            rsp_valid,
   input  logic                            rsp_ready,
   output logic                            rsp_write,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]                      rsp_resp,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
   output logic [2:0]                      M_AXI_AWPROT,
   output logic                            M_AXI_AWVALID,
   input  logic                            M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
   output logic                            M_AXI_WVALID,
   input  logic                            M_AXI_WREADY,
   input  logic [1:0]                      M_AXI_BRESP,
   input  logic                            M_AXI_BVALID,
   output logic                            M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
   output logic [2:0]                      M_AXI_ARPROT,
   output logic                            M_AXI_ARVALID,
   input  logic                            M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
   input  logic [1:0]                      M_AXI_RRESP,
   input  logic                            M_AXI_RVALID,
   output logic                            M_AXI_RREADY
);
   import axi_lite_pkg::*;

   localparam int SW = C_M_AXI_DATA_WIDTH / 8;

   state_t                        r_state,     w_state;
   logic                          r_cmd_ready, w_cmd_ready;
   logic                          r_awvalid,   w_awvalid;
   logic                          r_wvalid,    w_wvalid;
   logic                          r_bready,    w_bready;
   logic                          r_arvalid,   w_arvalid;
   logic                          r_rready,    w_rready;
   logic                          r_aw_done,   w_aw_done;
   logic                          r_w_done,    w_w_done;
   logic [C_M_AXI_ADDR_WIDTH-1:0] r_awaddr,    w_awaddr;
   logic [C_M_AXI_ADDR_WIDTH-1:0] r_araddr,    w_araddr;
   logic [C_M_AXI_DATA_WIDTH-1:0] r_wdata,     w_wdata;
   logic [SW-1:0]                 r_wstrb,     w_wstrb;
   logic                          r_rsp_valid, w_rsp_valid;
   logic                          r_rsp_write, w_rsp_write;
   logic [C_M_AXI_DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata;
   logic [1:0]                    r_rsp_resp,  w_rsp_resp;
   logic                          w_aw_hs;
   logic                          w_w_hs;

   assign w_aw_hs = r_awvalid && M_AXI_AWREADY;
   assign w_w_hs  = r_wvalid  && M_AXI_WREADY;

   // Next-state and next-output computation for the transaction FSM.
   always_comb begin
      w_state     = r_state;
      w_cmd_ready = r_cmd_ready;
      w_awvalid   = r_awvalid;
      w_wvalid    = r_wvalid;
      w_bready    = r_bready;
      w_arvalid   = r_arvalid;
      w_rready    = r_rready;
      w_aw_done   = r_aw_done;
      w_w_done    = r_w_done;
      w_awaddr    = r_awaddr;
      w_araddr    = r_araddr;
      w_wdata     = r_wdata;
      w_wstrb     = r_wstrb;
      w_rsp_valid = r_rsp_valid;
      w_rsp_write = r_rsp_write;
      w_rsp_rdata = r_rsp_rdata;
      w_rsp_resp  = r_rsp_resp;
      case (r_state)
         ST_IDLE: begin
            if (cmd_valid && r_cmd_ready) begin
               w_cmd_ready = 1'b0;
               w_rsp_write = cmd_write;
               if (cmd_write) begin
                  w_awaddr  = cmd_addr;
                  w_wdata   = cmd_wdata;
                  w_wstrb   = cmd_wstrb;
                  w_awvalid = 1'b1;
                  w_wvalid  = 1'b1;
                  w_aw_done = 1'b0;
                  w_w_done  = 1'b0;
                  w_state   = ST_WR;
               end else begin
                  w_araddr  = cmd_addr;
                  w_arvalid = 1'b1;
                  w_state   = ST_RADDR;
               end
            end else begin
               w_cmd_ready = 1'b1;
            end
         end
         ST_WR: begin
            // AW and W complete independently; leave only once both have been taken.
            if (w_aw_hs) begin
               w_awvalid = 1'b0;
               w_aw_done = 1'b1;
            end else begin
               w_aw_done = r_aw_done;
            end
            if (w_w_hs) begin
               w_wvalid = 1'b0;
               w_w_done = 1'b1;
            end else begin
               w_w_done = r_w_done;
            end
            if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
               w_bready = 1'b1;
               w_state  = ST_WRESP;
            end else begin
               w_state  = ST_WR;
            end
         end
         ST_WRESP: begin
            if (r_bready && M_AXI_BVALID) begin
               w_bready    = 1'b0;
               w_rsp_resp  = M_AXI_BRESP;
               w_rsp_rdata = {C_M_AXI_DATA_WIDTH{1'b0}};
               w_rsp_valid = 1'b1;
               w_state     = ST_RESP;
            end else begin
               w_state     = ST_WRESP;
            end
         end
         ST_RADDR: begin
            if (r_arvalid && M_AXI_ARREADY) begin
               w_arvalid = 1'b0;
               w_rready  = 1'b1;
               w_state   = ST_RDATA;
            end else begin
               w_state   = ST_RADDR;
            end
         end
         ST_RDATA: begin
            if (r_rready && M_AXI_RVALID) begin
               w_rready    = 1'b0;
               w_rsp_rdata = M_AXI_RDATA;
               w_rsp_resp  = M_AXI_RRESP;
               w_rsp_valid = 1'b1;
               w_state     = ST_RESP;
            end else begin
               w_state     = ST_RDATA;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_rsp_valid = 1'b0;
               w_cmd_ready = 1'b1;
               w_state     = ST_IDLE;
            end else begin
               w_state     = ST_RESP;
            end
         end
         default: begin
            w_state     = ST_IDLE;
            w_cmd_ready = 1'b1;
            w_awvalid   = 1'b0;
            w_wvalid    = 1'b0;
            w_bready    = 1'b0;
            w_arvalid   = 1'b0;
            w_rready    = 1'b0;
            w_rsp_valid = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETn) begin
      if (!M_AXI_ARESETn) begin
         r_state     <= ST_IDLE;
         r_cmd_ready <= 1'b1;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_awaddr    <= {C_M_AXI_ADDR_WIDTH{1'b0}};
         r_araddr    <= {C_M_AXI_ADDR_WIDTH{1'b0}};
         r_wdata     <= {C_M_AXI_DATA_WIDTH{1'b0}};
         r_wstrb     <= {SW{1'b0}};
         r_rsp_valid <= 1'b0;
         r_rsp_write <= 1'b0;
         r_rsp_rdata <= {C_M_AXI_DATA_WIDTH{1'b0}};
         r_rsp_resp  <= RESP_OKAY;
      end else begin
         r_state     <= w_state;
         r_cmd_ready <= w_cmd_ready;
         r_awvalid   <= w_awvalid;
         r_wvalid    <= w_wvalid;
         r_bready    <= w_bready;
         r_arvalid   <= w_arvalid;
         r_rready    <= w_rready;
         r_aw_done   <= w_aw_done;
         r_w_done    <= w_w_done;
         r_awaddr    <= w_awaddr;
         r_araddr    <= w_araddr;
         r_wdata     <= w_wdata;
         r_wstrb     <= w_wstrb;
         r_rsp_valid <= w_rsp_valid;
         r_rsp_write <= w_rsp_write;
         r_rsp_rdata <= w_rsp_rdata;
         r_rsp_resp  <= w_rsp_resp;
      end
   end

   assign cmd_ready     = r_cmd_ready;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_write     = r_rsp_write;
   assign rsp_rdata     = r_rsp_rdata;
   assign rsp_resp      = r_rsp_resp;
   assign M_AXI_AWADDR  = r_awaddr;
   assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
   assign M_AXI_AWVALID = r_awvalid;
   assign M_AXI_WDATA   = r_wdata;
   assign M_AXI_WSTRB   = r_wstrb;
   assign M_AXI_WVALID  = r_wvalid;
   assign M_AXI_BREADY  = r_bready;
   assign M_AXI_ARADDR  = r_araddr;
   assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
   assign M_AXI_ARVALID = r_arvalid;
   assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_m_axi_lite_cmd.sv
// Bench for m_axi_lite_cmd: a configurable-stall AXI4-Lite register slave plus a word-array reference model.
module tb_m_axi_lite_cmd;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [7:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [7:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;

   always #5 clk = ~clk;

   m_axi_lite_cmd #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(8)) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESETn(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
   );

   // ---------------- slave with per-channel stall configuration ----------------
   int          cfg_aw_delay = 0, cfg_w_delay = 0, cfg_b_delay = 0, cfg_ar_delay = 0, cfg_r_delay = 0;
   logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
   logic [31:0] mem [64];
   int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
   logic        got_aw, got_w, got_ar, wr_applied;
   logic [7:0]  aw_addr_q, ar_addr_q;
   logic [31:0] w_data_q;
   logic [3:0]  w_strb_q;
   logic        aw_now, w_now, ar_now;
   logic [7:0]  aw_addr_now, ar_addr_now;
   logic [31:0] w_data_now;
   logic [3:0]  w_strb_now;

   assign awready     = awvalid && (aw_cnt >= cfg_aw_delay);
   assign wready      = wvalid  && (w_cnt  >= cfg_w_delay);
   assign arready     = arvalid && (ar_cnt >= cfg_ar_delay);
   assign aw_now      = got_aw || (awvalid && awready);
   assign w_now       = got_w  || (wvalid && wready);
   assign ar_now      = got_ar || (arvalid && arready);
   assign aw_addr_now = got_aw ? aw_addr_q : awaddr;
   assign w_data_now  = got_w  ? w_data_q  : wdata;
   assign w_strb_now  = got_w  ? w_strb_q  : wstrb;
   assign ar_addr_now = got_ar ? ar_addr_q : araddr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
         got_aw <= 1'b0; got_w <= 1'b0; got_ar <= 1'b0; wr_applied <= 1'b0;
         aw_addr_q <= 8'h00; ar_addr_q <= 8'h00; w_data_q <= 32'h0; w_strb_q <= 4'h0;
         bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= 32'h0;
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      end else begin
         aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
         w_cnt  <= (wvalid && !wready)   ? w_cnt + 1  : 0;
         ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
         if (awvalid && awready) begin got_aw <= 1'b1; aw_addr_q <= awaddr; end
         if (wvalid && wready) begin got_w <= 1'b1; w_data_q <= wdata; w_strb_q <= wstrb; end
         if (arvalid && arready) begin got_ar <= 1'b1; ar_addr_q <= araddr; end
         if (aw_now && w_now && !wr_applied) begin
            wr_applied <= 1'b1;
            for (int b = 0; b < 4; b++)
               if (w_strb_now[b]) mem[aw_addr_now[7:2]][8*b +: 8] <= w_data_now[8*b +: 8];
         end
         if (bvalid && bready) begin
            bvalid <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0; wr_applied <= 1'b0; b_cnt <= 0;
         end else if (aw_now && w_now && !bvalid) begin
            if (b_cnt >= cfg_b_delay) begin bvalid <= 1'b1; bresp <= cfg_bresp; end
            else b_cnt <= b_cnt + 1;
         end
         if (rvalid && rready) begin
            rvalid <= 1'b0; got_ar <= 1'b0; r_cnt <= 0;
         end else if (ar_now && !rvalid) begin
            if (r_cnt >= cfg_r_delay) begin
               rvalid <= 1'b1; rresp <= cfg_rresp; rdata <= mem[ar_addr_now[7:2]];
            end else r_cnt <= r_cnt + 1;
         end
      end
   end

   // ---------------- passive protocol monitor ----------------
   int          stab_viol = 0, b_hs = 0;
   logic        p_aw, p_w, p_ar;
   logic [7:0]  p_awaddr, p_araddr;
   logic [35:0] p_wpay;

   always @(negedge clk) begin
      if (!rst_n) begin
         p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0;
      end else begin
         p_aw <= awvalid && !awready; p_awaddr <= awaddr;
         p_w  <= wvalid && !wready;   p_wpay   <= {wstrb, wdata};
         p_ar <= arvalid && !arready; p_araddr <= araddr;
         if (p_aw && (!awvalid || awaddr !== p_awaddr)) stab_viol <= stab_viol + 1;
         if (p_w && (!wvalid || {wstrb, wdata} !== p_wpay)) stab_viol <= stab_viol + 1;
         if (p_ar && (!arvalid || araddr !== p_araddr)) stab_viol <= stab_viol + 1;
         if (bvalid && bready) b_hs <= b_hs + 1;
      end
   end

   // ---------------- reference model and checking ----------------
   logic [31:0] model_mem [64];
   logic        exp_write;
   logic [31:0] exp_rdata;
   logic [1:0]  exp_resp;
   int          n_chk = 0, n_fail = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] br, input logic [1:0] rr);
      int t;
      cfg_bresp = br;
      cfg_rresp = rr;
      exp_write = wr;
      if (wr) begin
         for (int b = 0; b < 4; b++)
            if (s[b]) model_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
         exp_rdata = 32'h0;
         exp_resp  = br;
      end else begin
         exp_rdata = model_mem[a[7:2]];
         exp_resp  = rr;
      end
      cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
      t = 0;
      while (!cmd_ready && t < 100) begin step(); t++; end
      check_val("cmd_accept_timeout", cmd_ready, 1'b1);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic collect(input string tag, input int hold);
      int t;
      logic [35:0] snap;
      t = 0;
      while (!rsp_valid && t < 200) begin step(); t++; end
      check_val({tag, "_rsp_timeout"}, rsp_valid, 1'b1);
      snap = {rsp_write, rsp_resp, rsp_rdata, rsp_valid};
      for (int i = 0; i < hold; i++) begin
         step();
         check_val({tag, "_hold_stable"}, {rsp_write, rsp_resp, rsp_rdata, rsp_valid}, snap);
         check_val({tag, "_hold_quiet"}, {cmd_ready, awvalid, wvalid, arvalid, bready, rready}, 6'b0);
      end
      check_val({tag, "_rsp_write"}, rsp_write, exp_write);
      check_val({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
      check_val({tag, "_rsp_resp"}, rsp_resp, exp_resp);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      check_val({tag, "_after_rsp"}, {rsp_valid, cmd_ready}, 2'b01);
   endtask

   initial begin
      int t, b0;
      logic       wr;
      logic [7:0] a;
      logic [1:0] br, rr;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
      repeat (3) step();
      check_val("rst_cmd_ready", cmd_ready, 1'b1);
      check_val("rst_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
      check_val("rst_addr_data", {awaddr, araddr, wdata, wstrb, rsp_rdata}, 84'h0);
      check_val("rst_prot", {awprot, arprot}, 6'b0);
      rst_n = 1'b1;
      step();

      // zero-wait write: AW/W valid one cycle after accept, response two cycles later
      issue(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 2'b00, 2'b00);
      check_val("t1_n1_valids", {awvalid, wvalid, arvalid}, 3'b110);
      check_val("t1_n1_payload", {awaddr, wdata, wstrb}, {8'h10, 32'hDEADBEEF, 4'hF});
      step();
      check_val("t1_n2", {awvalid, wvalid, bready, rsp_valid}, 4'b0010);
      step();
      check_val("t1_n3_rsp_valid", rsp_valid, 1'b1);
      collect("t1", 0);

      // AWREADY held off: W completes first, AW stays stable, exactly one B
      cfg_aw_delay = 3;
      b0 = b_hs;
      issue(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 2'b00, 2'b00);
      check_val("t2_n1_valids", {awvalid, wvalid}, 2'b11);
      step();
      check_val("t2_n2_valids", {awvalid, wvalid}, 2'b10);
      check_val("t2_n2_awaddr", awaddr, 8'h10);
      collect("t2", 0);
      check_val("t2_b_count", b_hs - b0, 1);
      cfg_aw_delay = 0;

      issue(1'b0, 8'h10, 32'h0, 4'h0, 2'b00, 2'b00);
      collect("t3", 0);

      issue(1'b1, 8'h14, 32'hA5A5_0F0F, 4'hF, 2'b00, 2'b00);
      collect("t4", 5);

      issue(1'b1, 8'h18, 32'h1111_2222, 4'hF, 2'b10, 2'b00);
      collect("t5_slverr", 0);
      issue(1'b0, 8'h18, 32'h0, 4'h0, 2'b00, 2'b11);
      collect("t5_decerr", 0);

      // reset while waiting for B
      cfg_b_delay = 5;
      issue(1'b1, 8'h20, 32'h1234_5678, 4'hF, 2'b00, 2'b00);
      t = 0;
      while (!bready && t < 50) begin step(); t++; end
      check_val("t6_reach_wresp", bready, 1'b1);
      rst_n = 1'b0;
      #1;
      check_val("t6_valids_async", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
      check_val("t6_cmd_ready_in_reset", cmd_ready, 1'b1);
      for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
      cfg_b_delay = 0;
      repeat (2) step();
      rst_n = 1'b1;
      repeat (3) step();
      check_val("t6_after_release", {cmd_ready, rsp_valid}, 2'b10);
      issue(1'b1, 8'h20, 32'hCAFE_F00D, 4'hF, 2'b00, 2'b00);
      collect("t6_wr", 0);
      issue(1'b0, 8'h20, 32'h0, 4'h0, 2'b00, 2'b00);
      collect("t6_rd", 0);

      // randomized traffic over a small address window
      for (int k = 0; k < 40; k++) begin
         cfg_aw_delay = $urandom_range(0, 3);
         cfg_w_delay  = $urandom_range(0, 3);
         cfg_b_delay  = $urandom_range(0, 3);
         cfg_ar_delay = $urandom_range(0, 3);
         cfg_r_delay  = $urandom_range(0, 3);
         wr = 1'($urandom_range(0, 1));
         a  = 8'($urandom_range(0, 15)) << 2;
         br = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         issue(wr, a, $urandom, 4'($urandom_range(0, 15)), br, rr);
         collect("rand", $urandom_range(0, 2));
      end

      check_val("stability_violations", stab_viol, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
